// File: rtl/if_map_buffer_writer.sv
// Input feature-map writer: streams row elements into a circular buffer and
// records each row's first/last buffer address into the row start/end RAMs.
module if_map_buffer_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int ROW_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ROW_WIDTH:0]    num_rows,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  buf_wen,
   output logic [ADDR_WIDTH-1:0] buf_waddr,
   output logic [DATA_WIDTH-1:0] buf_wdata,
   output logic                  row_wen,
   output logic [ROW_WIDTH-1:0]  row_waddr,
   output logic [ADDR_WIDTH-1:0] row_start,
   output logic [ADDR_WIDTH-1:0] row_end,
   input  logic                  free_valid,
   input  logic [ADDR_WIDTH:0]   free_cnt,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ROW_WIDTH-1:0]  row_cnt;
   logic [ROW_WIDTH:0]    num_rows_q;
   logic                  first_flag;
   logic                  accept;
   logic                  last_row;
   logic                  underflow;
   logic [ADDR_WIDTH+1:0] occ_inc;
   logic [ADDR_WIDTH+1:0] occ_dec;
   logic [ADDR_WIDTH+1:0] occ_diff;
   logic [ADDR_WIDTH:0]   occ_next;

   assign in_ready  = (state == LOAD) && (occupancy < DEPTH);
   assign accept    = in_valid && in_ready;
   assign buf_wen   = accept;
   assign buf_waddr = wr_ptr;
   assign buf_wdata = in_data;
   assign row_wen   = (state == COMMIT);
   assign row_waddr = row_cnt;
   assign busy      = (state == LOAD) || (state == COMMIT);
   assign last_row  = ({1'b0, row_cnt} == (num_rows_q - (ROW_WIDTH+1)'(1)));

   // Accepted element and released elements land in the same cycle; an
   // over-release clamps at empty and raises the sticky error.
   assign occ_inc   = {1'b0, occupancy} + (ADDR_WIDTH+2)'(accept);
   assign occ_dec   = free_valid ? {1'b0, free_cnt} : '0;
   assign underflow = (occ_dec > occ_inc);
   assign occ_diff  = occ_inc - occ_dec;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      occ_next = occ_diff[ADDR_WIDTH:0];
      if (underflow)
         occ_next = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         occupancy  <= '0;
         row_cnt    <= '0;
         num_rows_q <= '0;
         first_flag <= 1'b1;
         row_start  <= '0;
         row_end    <= '0;
         err        <= 1'b0;
         done       <= 1'b0;
      end else begin
         occupancy <= occ_next;
         if (underflow)
            err <= 1'b1;
         if (accept)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

         case (state)
            IDLE, DONE: begin
               // Buffer pointer and occupancy carry over between loads.
               if (start) begin
                  num_rows_q <= num_rows;
                  row_cnt    <= '0;
                  first_flag <= 1'b1;
                  done       <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (first_flag) begin
                     row_start  <= wr_ptr;
                     first_flag <= 1'b0;
                  end
                  if (in_last) begin
                     row_end <= wr_ptr;
                     state   <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               row_cnt    <= row_cnt + ROW_WIDTH'(1);
               first_flag <= 1'b1;
               if (last_row) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_map_buffer_writer.sv
// Directed bench for if_map_buffer_writer: expected buffer writes and row
// records are queued as stimulus is driven and compared as the DUT emits them.
module tb_if_map_buffer_writer;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [RW:0]   num_rows;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic          buf_wen;
   logic [AW-1:0] buf_waddr;
   logic [DW-1:0] buf_wdata;
   logic          row_wen;
   logic [RW-1:0] row_waddr;
   logic [AW-1:0] row_start;
   logic [AW-1:0] row_end;
   logic          free_valid;
   logic [AW:0]   free_cnt;
   logic [AW:0]   occupancy;
   logic          busy;
   logic          done;
   logic          err;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   logic [AW+DW-1:0]   exp_wq[$];
   logic [RW+2*AW-1:0] exp_rq[$];
   logic [AW+DW-1:0]   w_exp;
   logic [RW+2*AW-1:0] r_exp;
   logic [AW-1:0]      m_ptr;
   int                 m_occ;

   always #5 clk = ~clk;

   if_map_buffer_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_rows   (num_rows),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .buf_wen    (buf_wen),
      .buf_waddr  (buf_waddr),
      .buf_wdata  (buf_wdata),
      .row_wen    (row_wen),
      .row_waddr  (row_waddr),
      .row_start  (row_start),
      .row_end    (row_end),
      .free_valid (free_valid),
      .free_cnt   (free_cnt),
      .occupancy  (occupancy),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every buffer write and row record must match the queue head.
   always @(negedge clk) begin
      if (buf_wen === 1'b1) begin
         if (exp_wq.size() == 0) begin
            check("buf_wen_unexpected", 64'(buf_wen), 64'd0);
         end else begin
            w_exp = exp_wq.pop_front();
            check("buf_waddr", 64'(buf_waddr), 64'(w_exp[AW+DW-1:DW]));
            check("buf_wdata", 64'(buf_wdata), 64'(w_exp[DW-1:0]));
         end
      end
      if (row_wen === 1'b1) begin
         if (exp_rq.size() == 0) begin
            check("row_wen_unexpected", 64'(row_wen), 64'd0);
         end else begin
            r_exp = exp_rq.pop_front();
            check("row_waddr", 64'(row_waddr), 64'(r_exp[RW+2*AW-1:2*AW]));
            check("row_start", 64'(row_start), 64'(r_exp[2*AW-1:AW]));
            check("row_end",   64'(row_end),   64'(r_exp[AW-1:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start    = 1'b1;
      num_rows = (RW+1)'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic do_free(input int n);
      free_valid = 1'b1;
      free_cnt   = (AW+1)'(n);
      tick();
      free_valid = 1'b0;
      m_occ = (n > m_occ) ? 0 : m_occ - n;
   endtask

   task automatic push_row(input int idx, input int n);
      logic [AW-1:0] e_end;
      e_end = m_ptr + AW'(n - 1);
      exp_rq.push_back({RW'(idx), m_ptr, e_end});
   endtask

   // Holds the element until the DUT is ready, then lets one edge take it.
   task automatic send_elem(input logic [DW-1:0] d, input logic last);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      exp_wq.push_back({m_ptr, d});
      m_ptr = m_ptr + AW'(1);
      m_occ++;
      @(negedge clk);
      while (in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("accept_wait", 64'(waited < 50), 64'd1);
      tick();
   endtask

   task automatic send_row(input int idx, input int n, input logic [DW-1:0] base);
      push_row(idx, n);
      for (int i = 0; i < n; i++)
         send_elem(base + DW'(i), (i == n - 1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done();
      int waited;
      waited = 0;
      @(negedge clk);
      while (done !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("done_wait", 64'(waited < 20), 64'd1);
      tick();
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_in_ready"},  64'(in_ready),  64'd0);
      check({pfx, "_busy"},      64'(busy),      64'd0);
      check({pfx, "_done"},      64'(done),      64'd0);
      check({pfx, "_err"},       64'(err),       64'd0);
      check({pfx, "_occupancy"}, 64'(occupancy), 64'd0);
      check({pfx, "_buf_wen"},   64'(buf_wen),   64'd0);
      check({pfx, "_row_wen"},   64'(row_wen),   64'd0);
      check({pfx, "_row_start"}, 64'(row_start), 64'd0);
      check({pfx, "_row_end"},   64'(row_end),   64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; num_rows = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      free_valid = 1'b0; free_cnt = '0;
      m_ptr = '0; m_occ = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      tick();

      // Two rows of four with in_valid held across the commit cycle.
      do_start(2);
      check("load_busy",     64'(busy),     64'd1);
      check("load_in_ready", 64'(in_ready), 64'd1);
      push_row(0, 4);
      for (int i = 0; i < 4; i++) send_elem(16'h1000 + DW'(i), (i == 3));
      send_row(1, 4, 16'h1010);
      wait_done();
      check("s1_done",      64'(done),      64'd1);
      check("s1_busy",      64'(busy),      64'd0);
      check("s1_in_ready",  64'(in_ready),  64'd0);
      check("s1_occupancy", 64'(occupancy), 64'(m_occ));

      // Accept and release in the same cycle.
      do_start(1);
      push_row(0, 4);
      send_elem(16'h2000, 1'b0);
      send_elem(16'h2001, 1'b0);
      check("s2_occ_before", 64'(occupancy), 64'(m_occ));
      free_valid = 1'b1;
      free_cnt   = 7'd3;
      send_elem(16'h2002, 1'b0);
      free_valid = 1'b0;
      m_occ = m_occ - 3;
      check("s2_occ_same_cycle", 64'(occupancy), 64'(m_occ));
      send_elem(16'h2003, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_done();
      check("s2_occupancy", 64'(occupancy), 64'(m_occ));

      // Releases honoured in DONE; over-release clamps and sets sticky err.
      do_free(7);
      check("s3_occ_free", 64'(occupancy), 64'(m_occ));
      check("s3_err_low",  64'(err),       64'd0);
      do_free(5);
      check("s3_occ_clamp", 64'(occupancy), 64'(m_occ));
      check("s3_err_set",   64'(err),       64'd1);
      repeat (3) tick();
      check("s3_err_sticky", 64'(err), 64'd1);
      do_start(1);
      check("s3_err_after_start", 64'(err),  64'd1);
      check("s3_busy",            64'(busy), 64'd1);

      // Reset mid-row: partial row discarded, no row record issued.
      send_elem(16'h3000, 1'b0);
      send_elem(16'h3001, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_reset("midrst");
      rst = 1'b0;
      m_ptr = '0;
      m_occ = 0;
      repeat (2) tick();
      check("midrst_idle_busy", 64'(busy), 64'd0);

      // Fill to 62, then a row that stalls at full and wraps the buffer.
      do_start(2);
      send_row(0, 62, 16'h4000);
      push_row(1, 4);
      send_elem(16'h5000, 1'b0);
      send_elem(16'h5001, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'h5002;
      in_last  = 1'b0;
      @(negedge clk);
      check("s4_full_occ",      64'(occupancy), 64'd64);
      check("s4_full_in_ready", 64'(in_ready),  64'd0);
      @(posedge clk);
      #1;
      in_data = 16'hdead;
      @(negedge clk);
      check("s4_stall_no_write", 64'(buf_wen), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      do_free(4);
      check("s4_occ_after_free",   64'(occupancy), 64'(m_occ));
      check("s4_ready_after_free", 64'(in_ready),  64'd1);
      send_elem(16'h5002, 1'b0);
      send_elem(16'h5003, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_done();
      check("s4_done",      64'(done),      64'd1);
      check("s4_occupancy", 64'(occupancy), 64'(m_occ));
      check("s4_row_start", 64'(row_start), 64'd62);
      check("s4_row_end",   64'(row_end),   64'd1);

      tick();
      check("write_queue_empty", 64'(exp_wq.size()), 64'd0);
      check("row_queue_empty",   64'(exp_rq.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
